// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_ram_arbiter
// Brief    : Two-master Wishbone classic arbiter in front of one single-port
//            wb_ram; one grant per transfer, stale RAM ack masked in IDLE.
//            WB_RAM_ARB_RR_EN selects round-robin (else fixed m0 priority).
// Revision : 1.0 - initial release
// ============================================================================
module wb_ram_arbiter #(
    parameter int dw = 32,
    parameter int aw = 10
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    output logic          m0_ack_o,
    output logic [dw-1:0] m0_dat_o,
    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    output logic          m1_ack_o,
    output logic [dw-1:0] m1_dat_o,
    output logic [aw-1:0] s_adr_o,
    output logic [dw-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    input  logic          s_ack_i,
    input  logic [dw-1:0] s_dat_i
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_gnt;
    logic   w_gnt_nxt;
    logic   w_req_any;
    logic   w_winner;
    logic   w_cyc_gnt;
    logic   w_we_gnt;

    assign w_req_any = m0_cyc_i | m1_cyc_i;

`ifdef WB_RAM_ARB_RR_EN
    logic r_last;
    logic w_last_nxt;

    // A conflict goes to the master that was not served most recently
    assign w_winner = (m0_cyc_i & m1_cyc_i) ? ~r_last : m1_cyc_i;
`else
    assign w_winner = ~m0_cyc_i;
`endif

    assign w_cyc_gnt = r_gnt ? m1_cyc_i : m0_cyc_i;
    assign w_we_gnt  = r_gnt ? m1_we_i  : m0_we_i;

    assign s_adr_o  = r_gnt ? m1_adr_i : m0_adr_i;
    assign s_dat_o  = r_gnt ? m1_dat_i : m0_dat_i;
    assign s_sel_o  = r_gnt ? m1_sel_i : m0_sel_i;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
`ifdef WB_RAM_ARB_RR_EN
            r_last  <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
`ifdef WB_RAM_ARB_RR_EN
            r_last  <= w_last_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
`ifdef WB_RAM_ARB_RR_EN
        w_last_nxt  = r_last;
`endif
        s_cyc_o     = 1'b0;
        s_we_o      = 1'b0;
        m0_ack_o    = 1'b0;
        m1_ack_o    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = ST_BUSY;
                    w_gnt_nxt   = w_winner;
                end
            end
            ST_BUSY: begin
                s_cyc_o  = w_cyc_gnt;
                s_we_o   = w_we_gnt;
                m0_ack_o = s_ack_i & w_cyc_gnt & ~r_gnt;
                m1_ack_o = s_ack_i & w_cyc_gnt & r_gnt;
                // Dropped cyc aborts without touching the round-robin pointer
                if (!w_cyc_gnt) begin
                    w_state_nxt = ST_IDLE;
                end else if (s_ack_i) begin
                    w_state_nxt = ST_IDLE;
`ifdef WB_RAM_ARB_RR_EN
                    w_last_nxt  = r_gnt;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
